prism_sit_bank: RTL and testbench

Parametrised, flop-based PRISM State Information Table (SIT) that holds DEPTH entries of WIDTH bits and serves NRD independent state-indexed read ports. Entries are programmed by random access over the 6-bit debug bus: the host fills a staging register, then commits it to an indexed entry with optional auto-increment. A sequential clear engine and a sticky lock are included, and any word of any entry can be read back. It sits between the debug/programming bus and the PRISM state-machine core, which indexes it with its current state every cycle.

---
 rtl/prism_sit_pkg.sv | 46 ++++
 rtl/prism_sit_rdport.sv | 52 +++++
 rtl/prism_sit_bank.sv | 219 +++++++++++++++++++++
 tb/tb_prism_sit_bank.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prism_sit_pkg.sv
// prism_sit_pkg: shared constants, types and helper functions for the
// PRISM State Information Table (SIT) bank.
//   - debug register addresses (word aligned, 6-bit debug bus)
//   - CTRL / STATUS / CMD bit positions
//   - control FSM state encoding
//   - sit_clog2 / sit_words elaboration helpers
package prism_sit_pkg;

  localparam logic [5:0] SIT_ADDR_CTRL   = 6'h00;
  localparam logic [5:0] SIT_ADDR_STATUS = 6'h04;
  localparam logic [5:0] SIT_ADDR_CMD    = 6'h08;
  localparam logic [5:0] SIT_ADDR_STAGE0 = 6'h10;
  localparam logic [5:0] SIT_ADDR_ENTRY0 = 6'h20;

  localparam int CTRL_AUTOINC_BIT = 8;
  localparam int CTRL_LOCK_BIT    = 31;
  localparam int STAT_ERR_BIT     = 1;
  localparam int CMD_COMMIT_BIT   = 0;
  localparam int CMD_CLEAR_BIT    = 1;

  typedef enum logic [1:0] {
    SIT_IDLE   = 2'd0,
    SIT_COMMIT = 2'd1,
    SIT_CLEAR  = 2'd2
  } sit_state_e;

  // Address bits needed for n entries, never less than one.
  function automatic int sit_clog2(input int n);
    int r;
    r = 32'sd1;
    for (int i = 32'sd1; i < 32'sd31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 32'sd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Number of 32-bit debug words needed to cover w bits.
  function automatic int sit_words(input int w);
    return (w + 32'sd31) / 32'sd32;
  endfunction

endpackage

// File: rtl/prism_sit_rdport.sv
// prism_sit_rdport: one state-indexed read port of the SIT bank.
//   clk, rst : clock and synchronous active-high reset (output register only)
//   mem      : the whole entry array
//   raddr    : entry index; indices at or above DEPTH return zero
//   rdata    : selected entry, combinational (REG_OUT=0) or one cycle late
module prism_sit_rdport
  import prism_sit_pkg::*;
#(
  parameter int WIDTH   = 80,
  parameter int DEPTH   = 8,
  parameter int A_BITS  = 3,
  parameter int REG_OUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  mem [DEPTH],
  input  logic [A_BITS-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] rdata_d;

  // Read mux with zero for out-of-range indices.
  always_comb begin
    rdata_d = '0;
    if (32'(raddr) < DEPTH) begin
      rdata_d = mem[raddr];
    end else begin
      rdata_d = '0;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] rdata_q;

      // Optional output register, cleared on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign rdata = rdata_q;
    end else begin : g_comb
      assign rdata = rdata_d;
    end
  endgenerate

endmodule

// File: rtl/prism_sit_bank.sv
// prism_sit_bank: flop-based PRISM State Information Table.
//   clk, rst          : clock, synchronous active-high reset
//   debug_addr/wr/wdata : 6-bit debug bus programming interface
//   debug_rdata       : combinational read-back of debug_addr
//   raddr / rdata     : NRD packed state-indexed read ports
//   busy              : commit or clear engine active
// Entries are written only by the commit/clear engine; the host fills the
// staging register and issues commands through CMD.
module prism_sit_bank
  import prism_sit_pkg::*;
#(
  parameter int WIDTH   = 80,
  parameter int DEPTH   = 8,
  parameter int NRD     = 2,
  parameter int REG_OUT = 0,
  parameter int A_BITS  = sit_clog2(DEPTH),
  parameter int WORDS   = sit_words(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              debug_addr,
  input  logic                    debug_wr,
  input  logic [31:0]             debug_wdata,
  output logic [31:0]             debug_rdata,
  input  logic [NRD*A_BITS-1:0]   raddr,
  output logic [NRD*WIDTH-1:0]    rdata,
  output logic                    busy
);

  localparam int PAD_W = WORDS * 32;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  stage_q, stage_d;
  logic [5:0]        index_q, index_d;
  logic              autoinc_q, autoinc_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;
  sit_state_e        state_q, state_d;
  logic [A_BITS-1:0] cidx_q, cidx_d;     // index latched when a commit is accepted
  logic              cinc_q, cinc_d;     // auto-increment latched with it
  logic [A_BITS-1:0] clr_cnt_q, clr_cnt_d;

  logic [PAD_W-1:0]  stage_pad;
  logic [PAD_W-1:0]  stage_wr_pad;
  logic [PAD_W-1:0]  entry_pad;
  logic [1:0]        word_sel;
  logic              word_ok;
  logic              is_stage;
  logic              is_entry;
  logic              index_ok;
  logic              cmd_any;
  logic              cmd_reject;

  assign busy     = (state_q != SIT_IDLE);
  assign word_sel = debug_addr[3:2];
  assign word_ok  = (32'(word_sel) < WORDS);
  assign is_stage = (debug_addr[5:4] == SIT_ADDR_STAGE0[5:4]) && (debug_addr[1:0] == 2'b00);
  assign is_entry = (debug_addr[5:4] == SIT_ADDR_ENTRY0[5:4]) && (debug_addr[1:0] == 2'b00);
  assign index_ok = (32'(index_q) < DEPTH);
  assign cmd_any  = debug_wdata[CMD_COMMIT_BIT] | debug_wdata[CMD_CLEAR_BIT];
  // A clear never depends on INDEX; only a commit needs it in range.
  assign cmd_reject = busy || lock_q || (!debug_wdata[CMD_CLEAR_BIT] && !index_ok);

  // Zero-extended views of staging and the INDEX-selected entry for word access.
  always_comb begin
    stage_pad = '0;
    stage_pad[WIDTH-1:0] = stage_q;
    entry_pad = '0;
    if (index_ok) begin
      entry_pad[WIDTH-1:0] = mem_q[index_q[A_BITS-1:0]];
    end else begin
      entry_pad = '0;
    end
  end

  // Host register writes, command acceptance and the commit/clear engine.
  always_comb begin
    mem_d        = mem_q;
    index_d      = index_q;
    autoinc_d    = autoinc_q;
    lock_d       = lock_q;
    err_d        = err_q;
    state_d      = state_q;
    cidx_d       = cidx_q;
    cinc_d       = cinc_q;
    clr_cnt_d    = clr_cnt_q;
    stage_wr_pad = stage_pad;

    if (debug_wr) begin
      if (debug_addr == SIT_ADDR_CTRL) begin
        index_d   = debug_wdata[5:0];
        autoinc_d = debug_wdata[CTRL_AUTOINC_BIT];
        lock_d    = lock_q | debug_wdata[CTRL_LOCK_BIT];
      end else if (debug_addr == SIT_ADDR_STATUS) begin
        if (debug_wdata[STAT_ERR_BIT]) begin
          err_d = 1'b0;
        end else begin
          err_d = err_q;
        end
      end else if (debug_addr == SIT_ADDR_CMD) begin
        if (!cmd_any) begin
          err_d = err_q;
        end else if (cmd_reject) begin
          err_d = 1'b1;
        end else if (debug_wdata[CMD_CLEAR_BIT]) begin
          state_d   = SIT_CLEAR;
          clr_cnt_d = '0;
        end else begin
          state_d = SIT_COMMIT;
          cidx_d  = index_q[A_BITS-1:0];
          cinc_d  = autoinc_q;
        end
      end else if (is_stage) begin
        if (word_ok) begin
          stage_wr_pad[{word_sel, 5'd0} +: 32] = debug_wdata;
        end else begin
          stage_wr_pad = stage_pad;
        end
      end else begin
        err_d = err_q;
      end
    end else begin
      err_d = err_q;
    end

    // The engine runs after the host write so a completing auto-increment
    // overrides an INDEX written in the same cycle.
    case (state_q)
      SIT_COMMIT: begin
        mem_d[cidx_q] = stage_q;
        state_d       = SIT_IDLE;
        if (cinc_q) begin
          if (32'(cidx_q) == DEPTH - 1) begin
            index_d = 6'd0;
          end else begin
            index_d = 6'(cidx_q) + 6'd1;
          end
        end else begin
          index_d = index_d;
        end
      end
      SIT_CLEAR: begin
        mem_d[clr_cnt_q] = '0;
        if (32'(clr_cnt_q) == DEPTH - 1) begin
          state_d = SIT_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = state_d;
      end
    endcase

    stage_d = stage_wr_pad[WIDTH-1:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      stage_q   <= '0;
      index_q   <= 6'd0;
      autoinc_q <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= SIT_IDLE;
      cidx_q    <= '0;
      cinc_q    <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      stage_q   <= stage_d;
      index_q   <= index_d;
      autoinc_q <= autoinc_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      state_q   <= state_d;
      cidx_q    <= cidx_d;
      cinc_q    <= cinc_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Debug read-back mux; unmapped addresses and absent words read zero.
  always_comb begin
    debug_rdata = 32'd0;
    if (debug_addr == SIT_ADDR_CTRL) begin
      debug_rdata = {lock_q, 22'd0, autoinc_q, 2'd0, index_q};
    end else if (debug_addr == SIT_ADDR_STATUS) begin
      debug_rdata = {29'd0, lock_q, err_q, busy};
    end else if (is_stage && word_ok) begin
      debug_rdata = stage_pad[{word_sel, 5'd0} +: 32];
    end else if (is_entry && word_ok) begin
      debug_rdata = entry_pad[{word_sel, 5'd0} +: 32];
    end else begin
      debug_rdata = 32'd0;
    end
  end

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_port
      prism_sit_rdport #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .A_BITS  (A_BITS),
        .REG_OUT (REG_OUT)
      ) u_port (
        .clk   (clk),
        .rst   (rst),
        .mem   (mem_q),
        .raddr (raddr[p*A_BITS +: A_BITS]),
        .rdata (rdata[p*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prism_sit_bank.sv
// Self-checking bench for prism_sit_bank (WIDTH=80, DEPTH=8, NRD=2, REG_OUT=0).
module tb_prism_sit_bank;

  localparam int WIDTH  = 80;
  localparam int DEPTH  = 8;
  localparam int NRD    = 2;
  localparam int A_BITS = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [5:0]            debug_addr;
  logic                  debug_wr;
  logic [31:0]           debug_wdata;
  logic [31:0]           debug_rdata;
  logic [NRD*A_BITS-1:0] raddr;
  logic [NRD*WIDTH-1:0]  rdata;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  prism_sit_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .REG_OUT(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .debug_addr  (debug_addr),
    .debug_wr    (debug_wr),
    .debug_wdata (debug_wdata),
    .debug_rdata (debug_rdata),
    .raddr       (raddr),
    .rdata       (rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_ent [DEPTH];
  logic [WIDTH-1:0] m_stage;
  int  m_idx;
  bit  m_ainc, m_lock, m_err;
  int  m_left;        // busy cycles still to come
  bit  m_job_clear;
  int  m_cidx;
  bit  m_cinc;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
    m_stage = '0; m_idx = 0; m_ainc = 0; m_lock = 0; m_err = 0;
    m_left = 0; m_job_clear = 0; m_cidx = 0; m_cinc = 0;
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step();
    logic [127:0] pad;
    bit was_busy, start_commit, start_clear;
    if (rst) begin
      model_reset();
      return;
    end
    was_busy = (m_left > 0);
    start_commit = 0; start_clear = 0;
    if (was_busy) begin
      if (m_job_clear) m_ent[DEPTH - m_left] = '0;
      else m_ent[m_cidx] = m_stage;
    end
    if (debug_wr) begin
      if (debug_addr == 6'h00) begin
        m_idx = int'(debug_wdata[5:0]);
        m_ainc = debug_wdata[8];
        if (debug_wdata[31]) m_lock = 1;
      end else if (debug_addr == 6'h04) begin
        if (debug_wdata[1]) m_err = 0;
      end else if (debug_addr == 6'h08) begin
        if (debug_wdata[1:0] != 2'b00) begin
          if (was_busy || m_lock || (!debug_wdata[1] && m_idx >= DEPTH)) m_err = 1;
          else if (debug_wdata[1]) start_clear = 1;
          else start_commit = 1;
        end
      end else if (debug_addr >= 6'h10 && debug_addr <= 6'h1C && debug_addr[1:0] == 2'b00) begin
        pad = 128'(m_stage);
        pad[32*int'(debug_addr[3:2]) +: 32] = debug_wdata;
        m_stage = pad[WIDTH-1:0];
      end
    end
    if (was_busy) begin
      if (!m_job_clear && m_cinc) m_idx = (m_cidx + 1) % DEPTH;
      m_left = m_left - 1;
    end
    if (start_clear) begin
      m_job_clear = 1; m_left = DEPTH;
    end else if (start_commit) begin
      m_job_clear = 0; m_left = 1; m_cidx = m_idx; m_cinc = m_ainc;
    end
  endtask

  function automatic logic [31:0] model_read(logic [5:0] a);
    logic [127:0] pad;
    if (a == 6'h00) return {m_lock, 22'd0, m_ainc, 2'd0, 6'(m_idx)};
    if (a == 6'h04) return {29'd0, m_lock, m_err, 1'(m_left > 0)};
    if (a >= 6'h10 && a <= 6'h1C && a[1:0] == 2'b00) begin
      pad = 128'(m_stage);
      return pad[32*int'(a[3:2]) +: 32];
    end
    if (a >= 6'h20 && a <= 6'h2C && a[1:0] == 2'b00) begin
      pad = (m_idx < DEPTH) ? 128'(m_ent[m_idx]) : 128'd0;
      return pad[32*int'(a[3:2]) +: 32];
    end
    return 32'd0;
  endfunction

  function automatic logic [WIDTH-1:0] model_port(logic [A_BITS-1:0] a);
    if (int'(a) < DEPTH) return m_ent[a];
    return '0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("busy", 128'(busy), 128'(m_left > 0));
      chk($sformatf("debug_rdata@%02h", debug_addr), 128'(debug_rdata), 128'(model_read(debug_addr)));
      for (int p = 0; p < NRD; p++)
        chk($sformatf("rdata%0d", p), 128'(rdata[p*WIDTH +: WIDTH]),
            128'(model_port(raddr[p*A_BITS +: A_BITS])));
    end
  end

  task automatic tick(bit w, logic [5:0] a, logic [31:0] d);
    debug_wr = w; debug_addr = a; debug_wdata = d;
    @(posedge clk);
    model_step();
    #1;
    debug_wr = 1'b0;
  endtask

  // Literal check of a debug register against both DUT and model.
  task automatic peek(logic [5:0] a, logic [31:0] exp, string name);
    debug_addr = a;
    #1;
    chk(name, 128'(debug_rdata), 128'(exp));
    chk({name, "_model"}, 128'(model_read(a)), 128'(exp));
  endtask

  task automatic peek_port(int p, logic [A_BITS-1:0] a, logic [WIDTH-1:0] exp, string name);
    raddr[p*A_BITS +: A_BITS] = a;
    #1;
    chk(name, 128'(rdata[p*WIDTH +: WIDTH]), 128'(exp));
    chk({name, "_model"}, 128'(model_port(a)), 128'(exp));
  endtask

  localparam logic [WIDTH-1:0] E3 = 80'hFFFF_12345678_DEADBEEF;
  localparam logic [WIDTH-1:0] E2 = 80'hFFFF_12345678_0BADF00D;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    logic [5:0] addrs [14];
    addrs = '{6'h00, 6'h04, 6'h08, 6'h08, 6'h08, 6'h10, 6'h14, 6'h18,
              6'h1C, 6'h20, 6'h24, 6'h28, 6'h2C, 6'h0C};
    rst = 1'b1; debug_wr = 1'b0; debug_addr = '0; debug_wdata = '0; raddr = '0;
    @(posedge clk); model_step(); #1;
    started = 1'b1;
    tick(0, 6'h00, 32'd0);
    rst = 1'b0;

    // Reset state
    peek(6'h04, 32'h0, "reset_status");
    peek(6'h20, 32'h0, "reset_entry0");
    chk("reset_busy", 128'(busy), 128'd0);
    tick(0, 6'h00, 32'd0);
    peek_port(0, 3'd3, '0, "reset_port0");
    peek_port(1, 3'd7, '0, "reset_port1");

    // Commit with auto-increment into entry 3
    tick(1, 6'h10, 32'hDEADBEEF);
    tick(1, 6'h14, 32'h12345678);
    tick(1, 6'h18, 32'h0000FFFF);
    tick(1, 6'h00, 32'h00000103);
    tick(1, 6'h08, 32'h1);
    chk("commit_busy", 128'(busy), 128'd1);
    tick(0, 6'h00, 32'd0);
    peek_port(0, 3'd3, E3, "commit_entry3");
    peek(6'h00, 32'h00000104, "commit_index");

    // Auto-increment wrap 7 -> 0 -> 1
    tick(1, 6'h00, 32'h00000107);
    tick(1, 6'h08, 32'h1);
    tick(0, 6'h00, 32'd0);
    tick(1, 6'h08, 32'h1);
    tick(0, 6'h00, 32'd0);
    peek_port(0, 3'd7, E3, "wrap_entry7");
    peek_port(1, 3'd0, E3, "wrap_entry0");
    peek(6'h00, 32'h00000101, "wrap_index");

    // Back-to-back commit: second is rejected
    tick(1, 6'h10, 32'h0BADF00D);
    tick(1, 6'h00, 32'h00000002);
    tick(1, 6'h08, 32'h1);
    tick(1, 6'h08, 32'h1);
    peek(6'h04, 32'h2, "reject_err");
    peek_port(0, 3'd2, E2, "reject_entry2");
    peek_port(1, 3'd3, E3, "reject_entry3_kept");
    tick(1, 6'h04, 32'h2);
    peek(6'h04, 32'h0, "err_cleared");
    peek(6'h20, 32'h0BADF00D, "entry_word0");
    peek(6'h28, 32'h0000FFFF, "entry_word2");
    tick(0, 6'h00, 32'd0);
    peek(6'h2C, 32'h0, "entry_word3_absent");
    peek(6'h1C, 32'h0, "stage_word3_absent");

    // Fill all entries, then clear-all
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 6'h10, 32'(100 + i));
      tick(1, 6'h00, 32'(i));
      tick(1, 6'h08, 32'h1);
      tick(0, 6'h00, 32'd0);
    end
    peek_port(1, 3'd5, 80'hFFFF_12345678_00000069, "fill_entry5");
    tick(1, 6'h08, 32'h2);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick(0, 6'h00, 32'd0);
    end
    chk("clear_busy_cycles", 128'(n), 128'd8);
    for (int a = 0; a < DEPTH; a++) begin
      peek_port(a % NRD, 3'(a), '0, $sformatf("cleared_entry%0d", a));
      tick(0, 6'h00, 32'd0);
    end

    // Lock blocks commit and clear until reset
    tick(1, 6'h00, 32'h80000005);
    tick(1, 6'h10, 32'h00000055);
    tick(1, 6'h08, 32'h1);
    tick(0, 6'h00, 32'd0);
    tick(1, 6'h08, 32'h2);
    tick(0, 6'h00, 32'd0);
    peek(6'h04, 32'h6, "lock_status");
    peek_port(0, 3'd5, '0, "lock_entry5");
    chk("lock_busy", 128'(busy), 128'd0);
    rst = 1'b1;
    tick(0, 6'h00, 32'd0);
    rst = 1'b0;
    peek(6'h04, 32'h0, "lock_after_rst");

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] a;
      logic [31:0] d;
      bit w;
      raddr = 6'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 99) < 60);
      a = ($urandom_range(0, 19) == 0) ? 6'($urandom) : addrs[$urandom_range(0, 13)];
      d = $urandom;
      if (a == 6'h00) begin
        d[31] = ($urandom_range(0, 59) == 0);
        d[5:0] = 6'($urandom_range(0, 9));
      end
      tick(w, a, d);
    end
    rst = 1'b0;
    tick(0, 6'h00, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
